lfsr_pingpong_interleaver: RTL and testbench
============================================

// Module: lfsr_pingpong_interleaver
// PURPOSE
//  Parametrised, double-buffered block interleaver/deinterleaver with LFSR address permutation.
//  Streams DATA_W-bit words in blocks of DEPTH = 2**ADDR_W over valid/ready handshakes.
//  Two RAM banks ping-pong: one bank fills while the other drains, so throughput is 1 word/clk.
//  Per-block mode: interleave (linear write, LFSR read) or deinterleave (LFSR write, linear read).
//  Sits between the framer and the channel encoder on the TX path and at the mirror point on RX.
// PARAMETERS
//  DATA_W  32       word width
//  ADDR_W  14       address width; block length DEPTH = 2**ADDR_W words
//  TAPS    14'h3802 feedback mask, must be primitive for ADDR_W (x^14+x^13+x^12+x^2+1)
//  SEED    1        nonzero LFSR start state, reloaded at the start of every block
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       async active-high reset
//  mode       in   1       0 = interleave, 1 = deinterleave; sampled on the first write of a block
//  in_valid   in   1       input word valid
//  in_ready   out  1       bank available for writing
//  in_data    in   DATA_W  input word
//  out_valid  out  1       output word valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  output word
//  out_last   out  1       marks the final word of a block
//  busy       out  1       any bank FULL or DRAINING, or any word in flight
// BEHAVIOUR
//  Reset: clears in_ready, out_valid, out_last, busy and out_data. Both banks go EMPTY. Write and read bank pointers go to 0.
//    Counters go to 0, both LFSRs load SEED, and the skid buffer is emptied. Release: in_ready=1 on the first clk.
//  Reset mid-block discards all stored and in-flight data. There is no partial-block flush.
//  Permutation: next = {q[ADDR_W-2:0], ^(q & TAPS)}. Sequence = SEED plus 2**ADDR_W-2 further nonzero states.
//    Address 0 is appended as the final (DEPTH-th) address, so the sequence is a full permutation of 0..DEPTH-1.
//  Bank states: EMPTY -> FILLING (first write) -> FULL (DEPTH-th write) -> DRAINING (first read issued) -> EMPTY (last read issued).
//  Write side:
//    - Word written when in_valid && in_ready. Address = wr_cnt (mode 0) or LFSR (mode 1).
//    - mode is latched per bank on the EMPTY->FILLING transition.
//    - On the DEPTH-th write, the bank goes FULL and the write pointer toggles.
//    - in_ready = (bank under write pointer is EMPTY or FILLING).
//  Read side:
//    - Bank under the read pointer is FULL/DRAINING. Address = LFSR (mode 0) or rd_cnt (mode 1), using that bank's latched mode.
//    - RAM is synchronous read, 1-cycle latency, into a 2-entry skid FIFO.
//    - A read issues only if skid occupancy + in-flight < 2. This gives 1 word/clk with out_ready held high.
//    - Latency: the DEPTH-th accepted write at cycle t gives the first read issue at t+1 and out_valid at t+2.
//  out_last travels with the word read at address index DEPTH-1 of the sequence. The read pointer toggles on that issue.
//  Simultaneous events:
//    - A write into one bank and a read of the other in the same cycle are always legal.
//    - A bank that goes EMPTY in cycle t may be written in cycle t+1 (in_ready rises at t+1).
//  Backpressure: out_ready=0 freezes skid contents and out_data. No word is dropped or duplicated.
//  mode changes mid-block are ignored until the next block boundary.
// STRUCTURE
//  Package lfsr_intlv_pkg:
//    - default TAPS table indexed by ADDR_W (4..16)
//    - bank-state enum {EMPTY, FILLING, FULL, DRAINING}
//    - MODE_INTLV / MODE_DEINTLV constants
//  Sub-module lfsr_addr_gen (ADDR_W, TAPS, SEED):
//    - ports: load, step, addr, last
//    - emits the full DEPTH-length permutation including the trailing 0
//    - instantiated twice: write side and read side
//  Top level holds: both bank FSMs, counters, 2 x DEPTH x DATA_W RAM (inferred), and the skid FIFO.
// TESTING (ADDR_W=4, TAPS=4'b1100, SEED=1; sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,0)
//  1. Interleave: mode=0, write d[k]=k for k=0..15, out_ready=1
//     -> out = 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8,0
//     -> out_last on the word 0; first out_valid 2 clk after the 16th write.
//  2. Round trip: interleaver output fed to a second instance in mode=1 -> 0..15 in order; out_last on 15.
//  3. Streaming: 4 back-to-back blocks, in_valid=out_ready=1
//     -> in_ready never drops after the first block; out_valid continuous; 64 words correct.
//  4. Backpressure: random out_ready at 30% with continuous input
//     -> in_ready=0 only when both banks are FULL/DRAINING; no loss or duplication vs. reference model.
//  5. Mode switch: block A mode=0, mode toggled mid-block A, block B mode=1
//     -> A fully interleaved, B fully deinterleaved.
//  6. Reset at write 7 of block 2 with block 1 draining
//     -> next cycle: out_valid=0, busy=0, in_ready=1; the next block output matches from a clean start.

Source files
------------

// File: rtl/lfsr_intlv_pkg.sv
// Shared definitions for the LFSR ping-pong interleaver: bank states,
// mode encodings and a table of known-good feedback masks.
package lfsr_intlv_pkg;

    localparam logic MODE_INTLV   = 1'b0;
    localparam logic MODE_DEINTLV = 1'b1;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Maximal-length feedback masks for the shift-left LFSR, indexed by width.
    function automatic logic [15:0] defaultTaps(input int addrW);
        logic [15:0] taps;
        case (addrW)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_addr_gen.sv
// LFSR address generator: walks SEED through all nonzero states, then emits
// address 0 as the final step so one block covers every address exactly once.
module lfsr_addr_gen
    import lfsr_intlv_pkg::*;
#(
    parameter int                ADDR_W = 14,
    parameter logic [ADDR_W-1:0] TAPS   = 14'h3802,
    parameter logic [ADDR_W-1:0] SEED   = ADDR_W'(1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] lfsr_q;
    logic              zero_q;
    logic [ADDR_W-1:0] lfsrNext;

    assign lfsrNext = {lfsr_q[ADDR_W-2:0], ^(lfsr_q & TAPS)};
    assign addr_o   = zero_q ? '0 : lfsr_q;
    assign last_o   = zero_q;

    // Advance the sequence; when it would return to SEED, emit the trailing 0 instead.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
            zero_q <= 1'b0;
        end else if (load_i) begin
            lfsr_q <= SEED;
            zero_q <= 1'b0;
        end else if (step_i && !zero_q) begin
            if (lfsrNext == SEED) begin
                zero_q <= 1'b1;
            end else begin
                lfsr_q <= lfsrNext;
            end
        end
    end

endmodule

// File: rtl/lfsr_pingpong_interleaver.sv
// Double-buffered block interleaver/deinterleaver. One RAM bank fills while
// the other drains; per-bank mode picks which side uses the LFSR order.
module lfsr_pingpong_interleaver
    import lfsr_intlv_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter int                ADDR_W = 14,
    parameter logic [ADDR_W-1:0] TAPS   = 14'h3802,
    parameter logic [ADDR_W-1:0] SEED   = ADDR_W'(1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              alive_q;
    bank_state_e       bankState_q [2];
    bank_state_e       bankState_d [2];
    logic [1:0]        bankMode_q, bankMode_d;
    logic              wrPtr_q, rdPtr_q;
    logic [ADDR_W-1:0] wrCnt_q, rdCnt_q;

    logic [ADDR_W-1:0] wrGenAddr, rdGenAddr;
    logic              wrGenLast, rdGenLast;
    logic              wrFire, wrMode, rdBankReady, rdIssue, rdMode;
    logic [ADDR_W-1:0] wrAddr, rdAddr;

    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [DATA_W-1:0] ramData_q;
    logic              ramLast_q, inFlight_q;

    logic [DATA_W-1:0] skidData_q [2];
    logic [DATA_W-1:0] skidData_d [2];
    logic [1:0]        skidLast_q, skidLast_d;
    logic [1:0]        skidCnt_q, skidCnt_d, cntAfterPop, occupancy;
    logic              outFire, popSkid, pushSkid;

    lfsr_addr_gen #(.ADDR_W(ADDR_W), .TAPS(TAPS), .SEED(SEED)) wrGen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (wrFire && wrGenLast),
        .step_i (wrFire),
        .addr_o (wrGenAddr),
        .last_o (wrGenLast)
    );

    lfsr_addr_gen #(.ADDR_W(ADDR_W), .TAPS(TAPS), .SEED(SEED)) rdGen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (rdIssue && rdGenLast),
        .step_i (rdIssue),
        .addr_o (rdGenAddr),
        .last_o (rdGenLast)
    );

    assign in_ready_o  = alive_q && (bankState_q[wrPtr_q] == BANK_EMPTY ||
                                     bankState_q[wrPtr_q] == BANK_FILLING);
    assign wrFire      = in_valid_i && in_ready_o;
    assign wrMode      = (bankState_q[wrPtr_q] == BANK_EMPTY) ? mode_i : bankMode_q[wrPtr_q];
    assign wrAddr      = (wrMode == MODE_DEINTLV) ? wrGenAddr : wrCnt_q;

    assign rdBankReady = (bankState_q[rdPtr_q] == BANK_FULL ||
                          bankState_q[rdPtr_q] == BANK_DRAINING);
    assign occupancy   = skidCnt_q + {1'b0, inFlight_q};
    assign rdIssue     = rdBankReady && (occupancy < 2'd2);
    assign rdMode      = bankMode_q[rdPtr_q];
    assign rdAddr      = (rdMode == MODE_INTLV) ? rdGenAddr : rdCnt_q;

    assign out_valid_o = (skidCnt_q != 2'd0) || inFlight_q;
    assign out_data_o  = (skidCnt_q != 2'd0) ? skidData_q[0] : (inFlight_q ? ramData_q : '0);
    assign out_last_o  = (skidCnt_q != 2'd0) ? skidLast_q[0] : (inFlight_q && ramLast_q);
    assign busy_o      = rdBankReady || (bankState_q[~rdPtr_q] == BANK_FULL) ||
                         (bankState_q[~rdPtr_q] == BANK_DRAINING) || out_valid_o;

    assign outFire     = out_valid_o && out_ready_i;
    assign popSkid     = outFire && (skidCnt_q != 2'd0);
    assign pushSkid    = inFlight_q && !(outFire && (skidCnt_q == 2'd0));

    // Bank lifecycle: the write side fills one bank while the read side drains the other.
    always_comb begin
        bankState_d[0] = bankState_q[0];
        bankState_d[1] = bankState_q[1];
        bankMode_d     = bankMode_q;
        if (wrFire) begin
            if (bankState_q[wrPtr_q] == BANK_EMPTY) begin
                bankMode_d[wrPtr_q] = mode_i;
            end
            bankState_d[wrPtr_q] = wrGenLast ? BANK_FULL : BANK_FILLING;
        end
        if (rdIssue) begin
            bankState_d[rdPtr_q] = rdGenLast ? BANK_EMPTY : BANK_DRAINING;
        end
    end

    // Skid FIFO: entry 0 is the head; RAM output bypasses it when the FIFO is empty.
    always_comb begin
        skidData_d  = skidData_q;
        skidLast_d  = skidLast_q;
        cntAfterPop = skidCnt_q;
        if (popSkid) begin
            skidData_d[0] = skidData_q[1];
            skidLast_d[0] = skidLast_q[1];
            cntAfterPop   = skidCnt_q - 2'd1;
        end
        skidCnt_d = cntAfterPop;
        if (pushSkid) begin
            skidData_d[cntAfterPop[0]] = ramData_q;
            skidLast_d[cntAfterPop[0]] = ramLast_q;
            skidCnt_d                  = cntAfterPop + 2'd1;
        end
    end

    // Dual-bank storage with registered read port; kept reset-free so it maps to block RAM.
    always_ff @(posedge clk_i) begin
        if (wrFire) begin
            mem[{wrPtr_q, wrAddr}] <= in_data_i;
        end
        if (rdIssue) begin
            ramData_q <= mem[{rdPtr_q, rdAddr}];
        end
    end

    // Control state: pointers, counters, bank FSMs, in-flight tracking and the skid FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alive_q        <= 1'b0;
            bankState_q[0] <= BANK_EMPTY;
            bankState_q[1] <= BANK_EMPTY;
            bankMode_q     <= '0;
            wrPtr_q        <= 1'b0;
            rdPtr_q        <= 1'b0;
            wrCnt_q        <= '0;
            rdCnt_q        <= '0;
            inFlight_q     <= 1'b0;
            ramLast_q      <= 1'b0;
            skidData_q[0]  <= '0;
            skidData_q[1]  <= '0;
            skidLast_q     <= '0;
            skidCnt_q      <= '0;
        end else begin
            alive_q        <= 1'b1;
            bankState_q[0] <= bankState_d[0];
            bankState_q[1] <= bankState_d[1];
            bankMode_q     <= bankMode_d;
            if (wrFire) begin
                wrCnt_q <= wrCnt_q + ADDR_W'(1);
                if (wrGenLast) begin
                    wrPtr_q <= ~wrPtr_q;
                end
            end
            if (rdIssue) begin
                rdCnt_q   <= rdCnt_q + ADDR_W'(1);
                ramLast_q <= rdGenLast;
                if (rdGenLast) begin
                    rdPtr_q <= ~rdPtr_q;
                end
            end
            inFlight_q    <= rdIssue;
            skidData_q[0] <= skidData_d[0];
            skidData_q[1] <= skidData_d[1];
            skidLast_q    <= skidLast_d;
            skidCnt_q     <= skidCnt_d;
        end
    end

endmodule

// File: tb/tb_lfsr_pingpong_interleaver.sv
// Directed bench for the ping-pong interleaver at ADDR_W=4 (16-word blocks).
module tb_lfsr_pingpong_interleaver;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    int PERM [DEPTH] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 0};
    int INV  [DEPTH];

    logic          clk, rst, mode, inValid, inReady, outValid, outReady, outLast, busy;
    logic [DW-1:0] inData, outData;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int readyMode   = 0;
    int lastWrCycle = 0;
    int stallCount  = 0;

    logic [DW-1:0] srcQ     [$];
    logic [DW-1:0] capData  [$];
    logic          capLast  [$];
    int            capCycle [$];
    logic [DW-1:0] intlvOut [DEPTH];

    lfsr_pingpong_interleaver #(
        .DATA_W (DW),
        .ADDR_W (4),
        .TAPS   (4'b1100),
        .SEED   (4'd1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_data_i   (inData),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_data_o  (outData),
        .out_last_o  (outLast),
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    // Downstream readiness: 0 = held low, 1 = held high, 2 = random 30% ready.
    initial begin
        outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       outReady = 1'b0;
                1:       outReady = 1'b1;
                default: outReady = ($urandom_range(0, 9) < 3);
            endcase
        end
    end

    // Capture every accepted output word with its cycle number.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            capData.push_back(outData);
            capLast.push_back(outLast);
            capCycle.push_back(cycle);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // Push srcQ through the input port; mode switches to m1 at word toggleAt.
    task automatic driveSource(input logic m0, input int toggleAt, input logic m1, input int stallFrom);
        int waits;
        @(posedge clk);
        #1;
        for (int k = 0; k < srcQ.size(); k++) begin
            if (k == 0) mode = m0;
            if (k == toggleAt) mode = m1;
            inValid = 1'b1;
            inData  = srcQ[k];
            waits   = 0;
            @(negedge clk);
            if (!inReady && k >= stallFrom) stallCount++;
            while (!inReady && waits < 1000) begin
                @(negedge clk);
                waits++;
            end
            if (!inReady) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL write_timeout word %0d: in_ready=%b required 1", k, inReady);
                inValid = 1'b0;
                return;
            end
            lastWrCycle = cycle;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
    endtask

    task automatic waitCaptures(input int target, input string name);
        int w = 0;
        while (capData.size() < target && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (capData.size() < target) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: captured %0d words, required %0d", name, capData.size(), target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors += 5;
        if (inReady !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b want 0", inReady); end
        if (outValid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b want 0", outValid); end
        if (outLast !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_last: got %b want 0", outLast); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        if (outData !== '0) begin miscompares++; $display("[TB] FAIL rst_out_data: got %h want 0", outData); end
        rst = 1'b0;
        readyMode = 1;
        @(posedge clk);
        #1;
        vectors += 2;
        if (inReady !== 1'b1) begin miscompares++; $display("[TB] FAIL release_in_ready: got %b want 1", inReady); end
        if (outValid !== 1'b0) begin miscompares++; $display("[TB] FAIL release_out_valid: got %b want 0", outValid); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_interleave();
        int base = capData.size();
        srcQ.delete();
        for (int k = 0; k < DEPTH; k++) srcQ.push_back(DW'(k));
        driveSource(1'b0, -1, 1'b0, 999);
        waitCaptures(base + DEPTH, "intlv_count");
        for (int i = 0; i < DEPTH; i++) begin
            vectors += 2;
            if (capData[base+i] !== DW'(PERM[i])) begin
                miscompares++;
                $display("[TB] FAIL intlv_data[%0d]: got %0d want %0d", i, capData[base+i], PERM[i]);
            end
            if (capLast[base+i] !== (i == DEPTH-1)) begin
                miscompares++;
                $display("[TB] FAIL intlv_last[%0d]: got %b want %b", i, capLast[base+i], (i == DEPTH-1));
            end
            intlvOut[i] = capData[base+i];
        end
        vectors++;
        if (capCycle[base] !== lastWrCycle + 2) begin
            miscompares++;
            $display("[TB] FAIL intlv_latency: first valid cycle %0d want %0d", capCycle[base], lastWrCycle + 2);
        end
    endtask

    task automatic test_round_trip();
        int base = capData.size();
        srcQ.delete();
        for (int k = 0; k < DEPTH; k++) srcQ.push_back(intlvOut[k]);
        driveSource(1'b1, -1, 1'b1, 999);
        waitCaptures(base + DEPTH, "roundtrip_count");
        for (int i = 0; i < DEPTH; i++) begin
            vectors += 2;
            if (capData[base+i] !== DW'(i)) begin
                miscompares++;
                $display("[TB] FAIL roundtrip_data[%0d]: got %0d want %0d", i, capData[base+i], i);
            end
            if (capLast[base+i] !== (i == DEPTH-1)) begin
                miscompares++;
                $display("[TB] FAIL roundtrip_last[%0d]: got %b want %b", i, capLast[base+i], (i == DEPTH-1));
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int base = capData.size();
        int gaps = 0;
        logic [DW-1:0] expd;
        srcQ.delete();
        for (int k = 0; k < 4*DEPTH; k++) srcQ.push_back(DW'(100 + k));
        stallCount = 0;
        driveSource(1'b0, -1, 1'b0, DEPTH);
        waitCaptures(base + 4*DEPTH, "stream_count");
        for (int i = 0; i < 4*DEPTH; i++) begin
            expd = DW'(100 + DEPTH*(i/DEPTH) + PERM[i%DEPTH]);
            vectors += 2;
            if (capData[base+i] !== expd) begin
                miscompares++;
                $display("[TB] FAIL stream_data[%0d]: got %0d want %0d", i, capData[base+i], expd);
            end
            if (capLast[base+i] !== ((i % DEPTH) == DEPTH-1)) begin
                miscompares++;
                $display("[TB] FAIL stream_last[%0d]: got %b want %b", i, capLast[base+i], ((i % DEPTH) == DEPTH-1));
            end
            if (i > 0 && capCycle[base+i] != capCycle[base+i-1] + 1) gaps++;
        end
        vectors += 2;
        if (stallCount !== 0) begin
            miscompares++;
            $display("[TB] FAIL stream_in_ready: %0d stalls after first block, want 0", stallCount);
        end
        if (gaps !== 0) begin
            miscompares++;
            $display("[TB] FAIL stream_out_valid: %0d gaps in output, want 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int base = capData.size();
        logic [DW-1:0] expd;
        srcQ.delete();
        for (int k = 0; k < 3*DEPTH; k++) srcQ.push_back(DW'(400 + k));
        readyMode = 2;
        fork
            driveSource(1'b0, -1, 1'b0, 999);
            begin
                logic          prevStall = 1'b0;
                logic [DW-1:0] prevData  = '0;
                int            w         = 0;
                while (capData.size() < base + 3*DEPTH && w < 5000) begin
                    @(negedge clk);
                    w++;
                    if (prevStall) begin
                        vectors++;
                        if (outValid !== 1'b1 || outData !== prevData) begin
                            miscompares++;
                            $display("[TB] FAIL bp_hold: valid=%b data=%0d want valid=1 data=%0d", outValid, outData, prevData);
                        end
                    end
                    prevStall = outValid && !outReady;
                    prevData  = outData;
                end
            end
        join
        readyMode = 1;
        repeat (4) @(posedge clk);
        vectors++;
        if (capData.size() - base !== 3*DEPTH) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d words want %0d", capData.size() - base, 3*DEPTH);
        end
        for (int i = 0; i < 3*DEPTH; i++) begin
            expd = DW'(400 + DEPTH*(i/DEPTH) + PERM[i%DEPTH]);
            vectors++;
            if (capData[base+i] !== expd) begin
                miscompares++;
                $display("[TB] FAIL bp_data[%0d]: got %0d want %0d", i, capData[base+i], expd);
            end
        end
    endtask

    task automatic test_mode_switch();
        int base = capData.size();
        logic [DW-1:0] expd;
        srcQ.delete();
        for (int k = 0; k < 2*DEPTH; k++) srcQ.push_back(DW'(200 + k));
        driveSource(1'b0, 8, 1'b1, 999);
        waitCaptures(base + 2*DEPTH, "mode_count");
        for (int i = 0; i < 2*DEPTH; i++) begin
            expd = (i < DEPTH) ? DW'(200 + PERM[i]) : DW'(200 + DEPTH + INV[i-DEPTH]);
            vectors++;
            if (capData[base+i] !== expd) begin
                miscompares++;
                $display("[TB] FAIL mode_data[%0d]: got %0d want %0d", i, capData[base+i], expd);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        srcQ.delete();
        for (int k = 0; k < DEPTH + 7; k++) srcQ.push_back(DW'(500 + k));
        driveSource(1'b0, -1, 1'b0, 999);
        rst = 1'b1;
        #1;
        vectors += 2;
        if (outValid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b want 0", outValid); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors += 3;
        if (inReady !== 1'b1) begin miscompares++; $display("[TB] FAIL postrst_in_ready: got %b want 1", inReady); end
        if (outValid !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_out_valid: got %b want 0", outValid); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL postrst_busy: got %b want 0", busy); end
        base = capData.size();
        srcQ.delete();
        for (int k = 0; k < DEPTH; k++) srcQ.push_back(DW'(600 + k));
        driveSource(1'b0, -1, 1'b0, 999);
        waitCaptures(base + DEPTH, "postrst_count");
        repeat (5) @(posedge clk);
        vectors += 2;
        if (capData.size() - base !== DEPTH) begin
            miscompares++;
            $display("[TB] FAIL postrst_words: got %0d want %0d", capData.size() - base, DEPTH);
        end
        if (capCycle[base] !== lastWrCycle + 2) begin
            miscompares++;
            $display("[TB] FAIL postrst_latency: first valid cycle %0d want %0d", capCycle[base], lastWrCycle + 2);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors += 2;
            if (capData[base+i] !== DW'(600 + PERM[i])) begin
                miscompares++;
                $display("[TB] FAIL postrst_data[%0d]: got %0d want %0d", i, capData[base+i], 600 + PERM[i]);
            end
            if (capLast[base+i] !== (i == DEPTH-1)) begin
                miscompares++;
                $display("[TB] FAIL postrst_last[%0d]: got %b want %b", i, capLast[base+i], (i == DEPTH-1));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) INV[PERM[i]] = i;
        rst     = 1'b1;
        mode    = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        test_reset();
        test_interleave();
        test_round_trip();
        test_back_to_back();
        test_backpressure();
        test_mode_switch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
